// File: rtl/timing_sequencer.sv
// Control-step sequencer: one-hot timing bus with programmable instruction length,
// direct step load, boundary-aligned halt/resume and a retired-instruction counter.
module timing_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int SW        = $clog2(NUM_STEPS),
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [SW-1:0]        last_step,
    input  logic                 load,
    input  logic [SW-1:0]        load_step,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic [NUM_STEPS-1:0] T,
    output logic [SW-1:0]        step,
    output logic                 wrap,
    output logic                 halted,
    output logic                 load_err,
    output logic [CNT_W-1:0]     inst_count
);
    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    localparam logic [SW-1:0] MAX_STEP = SW'(NUM_STEPS - 1);

    state_t            state, state_d;
    logic [SW-1:0]     step_d, last_eff;
    logic              pend, pend_d, err_d;
    logic [CNT_W-1:0]  cnt_d;

    // Compare in 32 bits so the clamp stays meaningful for every legal width.
    assign last_eff = (int'(last_step) > NUM_STEPS - 1) ? MAX_STEP : last_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            step       <= '0;
            pend       <= 1'b0;
            load_err   <= 1'b0;
            inst_count <= '0;
        end else begin
            state      <= state_d;
            step       <= step_d;
            pend       <= pend_d;
            load_err   <= err_d;
            inst_count <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        step_d  = step;
        pend_d  = pend;
        cnt_d   = inst_count;
        err_d   = 1'b0;
        wrap    = 1'b0;
        if (clr) begin
            state_d = RUN;
            step_d  = '0;
            pend_d  = 1'b0;
        end else if (state == HALTED) begin
            if (resume) begin
                state_d = RUN;
                step_d  = '0;
            end
        end else begin
            pend_d = pend | halt_req;
            if (load) begin
                if (load_step <= last_eff) step_d = load_step;
                else                       err_d  = 1'b1;
            end else if (en) begin
                // step above last_eff happens when last_step drops mid-instruction
                if (step >= last_eff) begin
                    wrap   = 1'b1;
                    step_d = '0;
                    cnt_d  = inst_count + 1'b1;
                    if (pend | halt_req) begin
                        state_d = HALTED;
                        pend_d  = 1'b0;
                    end
                end else begin
                    step_d = step + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_STEPS; i++) begin : g_dec
        assign T[i] = (state == RUN) && (step == SW'(i));
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_timing_sequencer.sv
// Scoreboard bench for timing_sequencer: a behavioural model queues expected
// register state per driven cycle; entries are popped and compared after the edge.
module tb_timing_sequencer;
    localparam int N  = 8;
    localparam int SW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          clr = 0, en = 0, load = 0, halt_req = 0, resume = 0;
    logic [SW-1:0] last_step = '0, load_step = '0;
    logic [N-1:0]  T;
    logic [SW-1:0] step;
    logic          wrap, halted, load_err;
    logic [CW-1:0] inst_count;

    timing_sequencer #(.NUM_STEPS(N), .SW(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .last_step(last_step),
        .load(load), .load_step(load_step), .halt_req(halt_req), .resume(resume),
        .T(T), .step(step), .wrap(wrap), .halted(halted), .load_err(load_err),
        .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  t;
        logic [SW-1:0] st;
        logic          hl;
        logic          er;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;

    // model state
    int m_step = 0, m_cnt = 0;
    bit m_run = 1, m_pend = 0, m_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.t   = m_run ? N'(1 << m_step) : '0;
        e.st  = SW'(m_step);
        e.hl  = !m_run;
        e.er  = m_err;
        e.cnt = CW'(m_cnt);
        return e;
    endfunction

    task automatic model_reset();
        m_step = 0; m_cnt = 0; m_run = 1; m_pend = 0; m_err = 0;
    endtask

    task automatic cyc(input bit c, input bit e, input int ls, input bit ld,
                       input int lst, input bit hr, input bit rs);
        int  le;
        bit  w;
        exp_t x;
        @(negedge clk);
        clr = c; en = e; last_step = SW'(ls); load = ld; load_step = SW'(lst);
        halt_req = hr; resume = rs;
        le = (ls > N - 1) ? N - 1 : ls;
        w  = m_run && !c && !ld && e && (m_step >= le);
        #1 check("wrap", 32'(wrap), 32'(w));
        m_err = 0;
        if (c) begin
            m_step = 0; m_run = 1; m_pend = 0;
        end else if (!m_run) begin
            if (rs) begin m_run = 1; m_step = 0; end
        end else begin
            if (ld) begin
                if (lst <= le) m_step = lst;
                else m_err = 1;
            end else if (e) begin
                if (w) begin
                    m_step = 0;
                    m_cnt  = (m_cnt + 1) % (1 << CW);
                    if (m_pend || hr) begin m_run = 0; hr = 0; m_pend = 0; end
                end else begin
                    m_step++;
                end
            end
            if (hr) m_pend = 1;
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check("T", 32'(T), 32'(x.t));
        check("step", 32'(step), 32'(x.st));
        check("halted", 32'(halted), 32'(x.hl));
        check("load_err", 32'(load_err), 32'(x.er));
        check("inst_count", 32'(inst_count), 32'(x.cnt));
    endtask

    task automatic run_en(input int n, input int ls);
        for (int i = 0; i < n; i++) cyc(0, 1, ls, 0, 0, 0, 0);
    endtask

    initial begin
        // reset state
        #12;
        check("rst_T", 32'(T), 32'h1);
        check("rst_step", 32'(step), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_load_err", 32'(load_err), 0);
        check("rst_cnt", 32'(inst_count), 0);
        @(negedge clk); rst_n = 1'b1;
        model_reset();

        // 4-step instruction twice
        run_en(8, 3);
        check("two_inst_cnt", 32'(inst_count), 2);

        // en toggling, 8-step instruction
        for (int i = 0; i < 16; i++) cyc(0, i % 2 == 0, 7, 0, 0, 0, 0);

        // load legal, then illegal, then lowered last_step forces wrap
        cyc(0, 1, 7, 0, 0, 0, 0);
        cyc(0, 1, 7, 1, 5, 0, 0);
        check("load_step5", 32'(step), 5);
        cyc(0, 0, 4, 1, 6, 0, 0);
        check("load_err_pulse", 32'(load_err), 1);
        cyc(0, 1, 4, 1, 2, 0, 0);  // load beats en
        cyc(0, 1, 2, 0, 0, 0, 0);  // step 2 == last_eff -> wrap
        cyc(0, 1, 7, 1, 6, 0, 0);
        cyc(0, 1, 3, 0, 0, 0, 0);  // step 6 > 3 -> wrap

        // halt at boundary, ignore inputs while halted, resume
        cyc(0, 1, 3, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 1, 0);
        run_en(2, 3);
        check("halt_T_zero", 32'(T), 0);
        check("halt_flag", 32'(halted), 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 3, i[0], 1, 1, 0);
        cyc(0, 0, 3, 0, 0, 0, 1);
        check("resume_T0", 32'(T), 1);

        // clr discards halt request
        run_en(2, 3);
        cyc(1, 1, 3, 0, 0, 1, 0);
        run_en(5, 3);
        check("clr_no_halt", 32'(halted), 0);

        // asynchronous reset mid-instruction
        run_en(2, 3);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_T", 32'(T), 1);
        check("async_cnt", 32'(inst_count), 0);
        check("async_step", 32'(step), 0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;

        // single-step instructions: counter wraps through 0
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            check("t0_hold", 32'(T), 1);
        end
        check("cnt_wrap", 32'(inst_count), 1);

        // random mix
        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7), $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
